// File: rtl/i2c_subordinate.sv
// I2C target endpoint: oversampled SCL/SDA, 7-bit address match,
// byte receive and transmit handshakes toward local logic.
module i2c_subordinate #(
    parameter logic [6:0] DEV_ADDR = 7'h50
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       SCL,
    inout  wire        SDA,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    input  logic [7:0] tx_data,
    output logic       tx_req,
    output logic       busy,
    output logic       start_det,
    output logic       stop_det,
    output logic       nack_rcvd
);

    typedef enum logic [2:0] {
        IDLE, ADDR, ADDR_ACK, RX_BYTE,
        RX_ACK, TX_BYTE, TX_ACK, IGNORE
    } state_t;

    state_t     state;
    logic [2:0] scl_q;
    logic [2:0] sda_q;
    logic [6:0] shreg;
    logic [6:0] txsh;
    logic [2:0] cnt;
    logic       sda_oe;
    logic       rw;
    logic       acc;
    logic       in_slot;

    logic scl_s, scl_h, sda_s, sda_h;
    logic scl_rise, scl_fall, start, stop;

    assign SDA = sda_oe ? 1'b0 : 1'bz;

    // [1:0] synchronizer stages, [2] history for edge detection
    always_ff @(posedge clk) begin
        if (rst) begin
            scl_q <= 3'b111;
            sda_q <= 3'b111;
        end else begin
            scl_q <= {scl_q[1:0], SCL};
            sda_q <= {sda_q[1:0], SDA};
        end
    end

    assign scl_s    = scl_q[1];
    assign scl_h    = scl_q[2];
    assign sda_s    = sda_q[1];
    assign sda_h    = sda_q[2];
    assign scl_rise = scl_s & ~scl_h;
    assign scl_fall = ~scl_s & scl_h;
    assign start    = scl_s & scl_h & sda_h & ~sda_s;
    assign stop     = scl_s & scl_h & ~sda_h & sda_s;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            sda_oe    <= 1'b0;
            busy      <= 1'b0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            tx_req    <= 1'b0;
            start_det <= 1'b0;
            stop_det  <= 1'b0;
            nack_rcvd <= 1'b0;
            shreg     <= '0;
            txsh      <= '0;
            cnt       <= '0;
            rw        <= 1'b0;
            acc       <= 1'b0;
            in_slot   <= 1'b0;
        end else begin
            rx_valid  <= 1'b0;
            tx_req    <= 1'b0;
            start_det <= 1'b0;
            stop_det  <= 1'b0;
            nack_rcvd <= 1'b0;
            if (start) begin
                state     <= ADDR;
                cnt       <= 3'd7;
                sda_oe    <= 1'b0;
                busy      <= 1'b0;
                in_slot   <= 1'b0;
                start_det <= 1'b1;
            end else if (stop) begin
                state    <= IDLE;
                sda_oe   <= 1'b0;
                busy     <= 1'b0;
                in_slot  <= 1'b0;
                stop_det <= 1'b1;
            end else begin
                unique case (state)
                    IDLE, IGNORE: sda_oe <= 1'b0;
                    ADDR: if (scl_rise) begin
                        shreg <= {shreg[5:0], sda_s};
                        cnt   <= cnt - 3'd1;
                        if (cnt == 3'd0) begin
                            rw      <= sda_s;
                            in_slot <= 1'b0;
                            state   <= (shreg == DEV_ADDR) ? ADDR_ACK : IGNORE;
                        end
                    end
                    // in_slot marks that the 9th clock is underway
                    ADDR_ACK: if (scl_fall) begin
                        if (!in_slot) begin
                            in_slot <= 1'b1;
                            sda_oe  <= 1'b1;
                            busy    <= 1'b1;
                        end else begin
                            in_slot <= 1'b0;
                            cnt     <= 3'd7;
                            if (rw) begin
                                txsh   <= tx_data[6:0];
                                sda_oe <= ~tx_data[7];
                                state  <= TX_BYTE;
                            end else begin
                                sda_oe <= 1'b0;
                                state  <= RX_BYTE;
                            end
                        end
                    end else if (scl_rise && in_slot && rw) begin
                        tx_req <= 1'b1;
                    end
                    RX_BYTE: if (scl_rise) begin
                        shreg <= {shreg[5:0], sda_s};
                        cnt   <= cnt - 3'd1;
                        if (cnt == 3'd0) begin
                            acc     <= rx_ready;
                            in_slot <= 1'b0;
                            state   <= RX_ACK;
                            if (rx_ready) begin
                                rx_data  <= {shreg, sda_s};
                                rx_valid <= 1'b1;
                            end
                        end
                    end
                    RX_ACK: if (scl_fall) begin
                        if (!in_slot) begin
                            in_slot <= 1'b1;
                            sda_oe  <= acc;
                            busy    <= acc;
                        end else begin
                            in_slot <= 1'b0;
                            sda_oe  <= 1'b0;
                            cnt     <= 3'd7;
                            state   <= acc ? RX_BYTE : IGNORE;
                        end
                    end
                    // cnt wraps to 7 on the 8th rise, ending the byte
                    TX_BYTE: if (scl_rise) begin
                        cnt <= cnt - 3'd1;
                    end else if (scl_fall) begin
                        if (cnt == 3'd7) begin
                            sda_oe  <= 1'b0;
                            in_slot <= 1'b0;
                            state   <= TX_ACK;
                        end else begin
                            sda_oe <= ~txsh[cnt];
                        end
                    end
                    TX_ACK: if (scl_rise && !in_slot) begin
                        if (sda_s) begin
                            nack_rcvd <= 1'b1;
                            busy      <= 1'b0;
                            state     <= IGNORE;
                        end else begin
                            tx_req  <= 1'b1;
                            in_slot <= 1'b1;
                        end
                    end else if (scl_fall && in_slot) begin
                        in_slot <= 1'b0;
                        cnt     <= 3'd7;
                        txsh    <= tx_data[6:0];
                        sda_oe  <= ~tx_data[7];
                        state   <= TX_BYTE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_subordinate.sv
// Bench for i2c_subordinate: bus master model, write vector table,
// rx scoreboard and hand-written read / restart / reset sequences.
module tb_i2c_subordinate;

    localparam int Q = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       SCL = 1'b1;
    logic       m_oe = 1'b0;
    logic       rx_ready = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic [7:0] rx_data;
    logic       rx_valid, tx_req, busy;
    logic       start_det, stop_det, nack_rcvd;
    wire        sda_bus;

    assign sda_bus = m_oe ? 1'b0 : 1'bz;
    pullup (sda_bus);

    always #5 clk = ~clk;

    i2c_subordinate #(.DEV_ADDR(7'h50)) dut (
        .clk(clk), .rst(rst), .SCL(SCL), .SDA(sda_bus),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .tx_data(tx_data), .tx_req(tx_req), .busy(busy),
        .start_det(start_det), .stop_det(stop_det), .nack_rcvd(nack_rcvd)
    );

    int tests = 0;
    int fails = 0;
    int n_rxv = 0, n_txr = 0, n_start = 0, n_stop = 0, n_nack = 0;
    int dut_low = 0;
    logic [7:0] rxq[$];
    logic [7:0] txq[$];
    logic [4:0] p_pulse = '0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        p_pulse <= {rx_valid, tx_req, start_det, stop_det, nack_rcvd};
        if (p_pulse != 0)
            check("pulse_width", 32'(p_pulse & {rx_valid, tx_req,
                  start_det, stop_det, nack_rcvd}), 0);
        if (!m_oe && sda_bus === 1'b0) dut_low++;
        if (start_det) n_start++;
        if (stop_det) n_stop++;
        if (nack_rcvd) n_nack++;
        if (tx_req) begin
            n_txr++;
            if (txq.size() > 0) tx_data = txq.pop_front();
        end
        if (rx_valid) begin
            n_rxv++;
            if (rxq.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL rx_unexpected: got %0h, want none", rx_data);
            end else begin
                check("rx_data", rx_data, rxq.pop_front());
            end
        end
    end

    task automatic wq();
        repeat (Q) @(negedge clk);
    endtask

    task automatic mbit(input logic b, output logic r);
        m_oe = !b;
        wq(); SCL = 1'b1;
        wq(); r = sda_bus;
        wq(); SCL = 1'b0;
        wq();
    endtask

    task automatic mstart();
        m_oe = 1'b0;
        wq(); SCL = 1'b1;
        wq(); m_oe = 1'b1;
        wq(); SCL = 1'b0;
        wq();
    endtask

    task automatic mstop();
        m_oe = 1'b1;
        wq(); SCL = 1'b1;
        wq(); m_oe = 1'b0;
        wq();
    endtask

    task automatic wbyte(input logic [7:0] d, output logic ack_n);
        logic r;
        for (int i = 7; i >= 0; i--) mbit(d[i], r);
        mbit(1'b1, ack_n);
    endtask

    task automatic rbyte(input logic nack, output logic [7:0] d);
        logic r;
        for (int i = 7; i >= 0; i--) begin
            mbit(1'b1, r);
            d[i] = r;
        end
        mbit(nack, r);
    endtask

    typedef struct {
        logic [6:0]  addr;
        int          n;
        logic [23:0] d;
        logic [2:0]  rdy;
        logic [3:0]  ack;
        int          nrx;
    } wvec_t;

    wvec_t vt[5];

    initial begin
        logic       a;
        logic [7:0] d;
        int s_rx, s_st, s_sp, s_tx, s_nk;

        vt[0] = '{7'h50, 1, 24'h0000A5, 3'b001, 4'b0011, 1};
        vt[1] = '{7'h51, 1, 24'h000000, 3'b001, 4'b0000, 0};
        vt[2] = '{7'h50, 3, 24'h332211, 3'b101, 4'b0011, 1};
        vt[3] = '{7'h28, 2, 24'h0000FF, 3'b011, 4'b0000, 0};
        vt[4] = '{7'h50, 2, 24'h00FF00, 3'b011, 4'b0111, 2};

        repeat (5) @(negedge clk);
        check("reset_outs", {rx_data, rx_valid, tx_req, busy, start_det,
              stop_det, nack_rcvd}, 0);
        check("reset_sda", sda_bus, 1);
        rst = 1'b0;
        repeat (10) @(negedge clk);

        for (int v = 0; v < 5; v++) begin
            s_rx = n_rxv; s_st = n_start; s_sp = n_stop;
            dut_low = 0;
            mstart();
            wbyte({vt[v].addr, 1'b0}, a);
            check($sformatf("v%0d_addr_ack", v), a, !vt[v].ack[0]);
            check($sformatf("v%0d_busy", v), busy, vt[v].ack[0]);
            for (int i = 0; i < vt[v].n; i++) begin
                rx_ready = vt[v].rdy[i];
                if (vt[v].ack[i+1]) rxq.push_back(vt[v].d[8*i +: 8]);
                wbyte(vt[v].d[8*i +: 8], a);
                check($sformatf("v%0d_b%0d_ack", v, i), a, !vt[v].ack[i+1]);
            end
            mstop();
            wq();
            check($sformatf("v%0d_rx_cnt", v), n_rxv - s_rx, vt[v].nrx);
            check($sformatf("v%0d_start", v), n_start - s_st, 1);
            check($sformatf("v%0d_stop", v), n_stop - s_sp, 1);
            check($sformatf("v%0d_busy_end", v), busy, 0);
            check($sformatf("v%0d_drove", v), dut_low != 0, vt[v].ack != 0);
        end
        rx_ready = 1'b1;

        // read two bytes, ACK then NACK
        s_tx = n_txr; s_nk = n_nack;
        txq.push_back(8'h3C);
        txq.push_back(8'hC3);
        mstart();
        wbyte(8'hA1, a);
        check("rd_addr_ack", a, 0);
        rbyte(1'b0, d);
        check("rd_byte0", d, 8'h3C);
        rbyte(1'b1, d);
        check("rd_byte1", d, 8'hC3);
        check("rd_release", sda_bus, 1);
        check("rd_busy", busy, 0);
        mstop();
        wq();
        check("rd_tx_req", n_txr - s_tx, 2);
        check("rd_nack", n_nack - s_nk, 1);

        // write then repeated START into a read
        s_st = n_start; s_rx = n_rxv; s_nk = n_nack;
        mstart();
        wbyte(8'hA0, a);
        rxq.push_back(8'h12);
        wbyte(8'h12, a);
        check("rs_wr_ack", a, 0);
        txq.push_back(8'h5A);
        mstart();
        wbyte(8'hA1, a);
        check("rs_rd_addr_ack", a, 0);
        rbyte(1'b1, d);
        check("rs_rd_byte", d, 8'h5A);
        mstop();
        wq();
        check("rs_start_cnt", n_start - s_st, 2);
        check("rs_rx_cnt", n_rxv - s_rx, 1);
        check("rs_nack", n_nack - s_nk, 1);

        // reset while the target drives a 0 data bit
        txq.push_back(8'h00);
        mstart();
        wbyte(8'hA1, a);
        check("rr_addr_ack", a, 0);
        check("rr_drive0", sda_bus, 0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rr_sda_rel", sda_bus, 1);
        check("rr_outs", {rx_data, rx_valid, tx_req, busy, start_det,
              stop_det, nack_rcvd}, 0);
        mstop();
        wq();
        s_rx = n_rxv;
        mstart();
        wbyte(8'hA0, a);
        check("rr_wr_addr_ack", a, 0);
        rxq.push_back(8'h77);
        wbyte(8'h77, a);
        check("rr_wr_ack", a, 0);
        mstop();
        wq();
        check("rr_rx_cnt", n_rxv - s_rx, 1);
        check("rxq_empty", rxq.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
